// File: rtl/uart_wb_pkg.sv
// Shared definitions for the UART-to-Wishbone bridge: command codes, state
// encodings and the bit-period calculation.
package uart_wb_pkg;

    localparam logic [7:0] CMD_WR_INC = 8'h01;
    localparam logic [7:0] CMD_RD_INC = 8'h02;
    localparam logic [7:0] CMD_WR_FIX = 8'h03;
    localparam logic [7:0] CMD_RD_FIX = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN, ST_ADDR, ST_WDATA, ST_WBUS, ST_RBUS, ST_RSEND
    } state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK
    } rx_state_t;

    // Clocks per UART bit, rounded to nearest.
    function automatic int bit_period(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

    function automatic logic cmd_valid(input logic [7:0] cmd);
        return (cmd == CMD_WR_INC) || (cmd == CMD_RD_INC) ||
               (cmd == CMD_WR_FIX) || (cmd == CMD_RD_FIX);
    endfunction

endpackage

// File: rtl/uart_byte_phy.sv
// 8N1 UART byte receiver and transmitter with valid/ready byte handshakes.
// A byte with a low stop bit raises rx_ferr for one clock instead of rx_valid.
module uart_byte_phy
    import uart_wb_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_ferr,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready
);
    localparam int BIT_P  = bit_period(CLK_FREQ, BAUD);
    localparam int HALF_P = (BIT_P > 1) ? BIT_P / 2 : 1;
    localparam int CW     = $clog2(BIT_P + 1);

    logic            rx_meta_reg, rx_sync_reg;
    rx_state_t       rx_state_reg;
    logic [CW-1:0]   rx_cnt_reg;
    logic [2:0]      rx_bit_reg;
    logic [7:0]      rx_shift_reg;
    logic [7:0]      rx_data_reg;
    logic            rx_valid_reg, rx_ferr_reg;

    logic            tx_busy_reg, tx_line_reg;
    logic [CW-1:0]   tx_cnt_reg;
    logic [3:0]      tx_bits_reg;
    logic [8:0]      tx_shift_reg;

    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign rx_ferr  = rx_ferr_reg;
    assign uart_tx  = tx_line_reg;
    assign tx_ready = ~tx_busy_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
            rx_ferr_reg  <= 1'b0;
        end else begin
            rx_meta_reg <= uart_rx;
            rx_sync_reg <= rx_meta_reg;
            rx_ferr_reg <= 1'b0;
            if (rx_valid_reg && rx_ready)
                rx_valid_reg <= 1'b0;
            case (rx_state_reg)
                RX_IDLE: begin
                    rx_cnt_reg <= '0;
                    if (!rx_sync_reg)
                        rx_state_reg <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt_reg == CW'(HALF_P - 1)) begin
                        rx_cnt_reg   <= '0;
                        rx_bit_reg   <= '0;
                        rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_reg == CW'(BIT_P - 1)) begin
                        rx_cnt_reg   <= '0;
                        rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
                        rx_bit_reg   <= rx_bit_reg + 3'd1;
                        if (rx_bit_reg == 3'd7)
                            rx_state_reg <= RX_STOP;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_reg == CW'(BIT_P - 1)) begin
                        rx_cnt_reg <= '0;
                        if (rx_sync_reg) begin
                            rx_data_reg  <= rx_shift_reg;
                            rx_valid_reg <= 1'b1;
                            rx_state_reg <= RX_IDLE;
                        end else begin
                            rx_ferr_reg  <= 1'b1;
                            rx_state_reg <= RX_BREAK;
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + CW'(1);
                    end
                end
                // Wait for the line to return high so a long low is not
                // mistaken for a fresh start bit.
                RX_BREAK: begin
                    if (rx_sync_reg)
                        rx_state_reg <= RX_IDLE;
                end
                default: rx_state_reg <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy_reg  <= 1'b0;
            tx_line_reg  <= 1'b1;
            tx_cnt_reg   <= '0;
            tx_bits_reg  <= '0;
            tx_shift_reg <= '0;
        end else if (!tx_busy_reg) begin
            if (tx_valid) begin
                tx_busy_reg  <= 1'b1;
                tx_line_reg  <= 1'b0;
                tx_cnt_reg   <= '0;
                tx_bits_reg  <= 4'd9;
                tx_shift_reg <= {1'b1, tx_data};
            end
        end else if (tx_cnt_reg == CW'(BIT_P - 1)) begin
            tx_cnt_reg <= '0;
            if (tx_bits_reg != 4'd0) begin
                tx_line_reg  <= tx_shift_reg[0];
                tx_shift_reg <= {1'b1, tx_shift_reg[8:1]};
                tx_bits_reg  <= tx_bits_reg - 4'd1;
            end else begin
                tx_busy_reg <= 1'b0;
            end
        end else begin
            tx_cnt_reg <= tx_cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/uart_wb_bridge.sv
// Protocol FSM turning UART command frames into Wishbone master cycles and
// streaming read data back over the UART.
module uart_wb_bridge
    import uart_wb_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 30,
    parameter int TIMEOUT  = 1000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                uart_rx,
    output logic                uart_tx,
    output logic                wb_cyc,
    output logic                wb_stb,
    output logic                wb_we,
    output logic [ADDR_W-1:0]   wb_adr,
    output logic [DATA_W-1:0]   wb_dat_w,
    output logic [DATA_W/8-1:0] wb_sel,
    input  logic [DATA_W-1:0]   wb_dat_r,
    input  logic                wb_ack,
    input  logic                wb_err
);
    localparam int BYTES = DATA_W / 8;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    logic [7:0]        rx_data;
    logic              rx_valid, rx_ready, rx_ferr, tx_ready;
    logic [7:0]        tx_data_reg;
    logic              tx_valid_reg;

    state_t            state_reg;
    logic              we_mode_reg, inc_mode_reg, err_flag_reg;
    logic [8:0]        words_left_reg;
    logic [3:0]        byte_cnt_reg;
    logic [23:0]       addr_shift_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_shift_reg, rdata_reg;
    logic [TO_W-1:0]   idle_cnt_reg;

    logic              rx_fire, in_rx_state, abort;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] wdata_next, rd_word;

    uart_byte_phy #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_phy (
        .clk      (clk),
        .rst_n    (rst_n),
        .uart_rx  (uart_rx),
        .uart_tx  (uart_tx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_ferr  (rx_ferr),
        .tx_data  (tx_data_reg),
        .tx_valid (tx_valid_reg),
        .tx_ready (tx_ready)
    );

    // Hold incoming bytes in the phy while a write is on the bus.
    assign rx_ready    = (state_reg != ST_WBUS);
    assign rx_fire     = rx_valid && rx_ready;
    assign in_rx_state = (state_reg == ST_LEN) || (state_reg == ST_ADDR) ||
                         (state_reg == ST_WDATA);
    assign abort       = rx_ferr || (!rx_fire && idle_cnt_reg == TO_W'(TIMEOUT));
    assign addr_next   = ADDR_W'({addr_shift_reg, rx_data});
    assign wdata_next  = DATA_W'({wdata_shift_reg, rx_data});
    assign rd_word     = wb_err ? '0 : wb_dat_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            we_mode_reg     <= 1'b0;
            inc_mode_reg    <= 1'b0;
            err_flag_reg    <= 1'b0;
            words_left_reg  <= '0;
            byte_cnt_reg    <= '0;
            addr_shift_reg  <= '0;
            addr_reg        <= '0;
            wdata_shift_reg <= '0;
            rdata_reg       <= '0;
            idle_cnt_reg    <= '0;
            tx_data_reg     <= '0;
            tx_valid_reg    <= 1'b0;
            wb_cyc          <= 1'b0;
            wb_stb          <= 1'b0;
            wb_we           <= 1'b0;
            wb_adr          <= '0;
            wb_dat_w        <= '0;
            wb_sel          <= '0;
        end else begin
            if (rx_fire || !in_rx_state)
                idle_cnt_reg <= '0;
            else
                idle_cnt_reg <= idle_cnt_reg + TO_W'(1);

            case (state_reg)
                ST_IDLE: begin
                    if (rx_fire && cmd_valid(rx_data)) begin
                        we_mode_reg  <= (rx_data == CMD_WR_INC) || (rx_data == CMD_WR_FIX);
                        inc_mode_reg <= (rx_data == CMD_WR_INC) || (rx_data == CMD_RD_INC);
                        state_reg    <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (abort) begin
                        state_reg <= ST_IDLE;
                    end else if (rx_fire) begin
                        words_left_reg <= {rx_data == 8'd0, rx_data};
                        byte_cnt_reg   <= '0;
                        state_reg      <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (abort) begin
                        state_reg <= ST_IDLE;
                    end else if (rx_fire) begin
                        addr_shift_reg <= {addr_shift_reg[15:0], rx_data};
                        byte_cnt_reg   <= byte_cnt_reg + 4'd1;
                        if (byte_cnt_reg == 4'd3) begin
                            addr_reg     <= addr_next;
                            byte_cnt_reg <= '0;
                            err_flag_reg <= 1'b0;
                            if (we_mode_reg) begin
                                state_reg <= ST_WDATA;
                            end else begin
                                wb_cyc    <= 1'b1;
                                wb_stb    <= 1'b1;
                                wb_we     <= 1'b0;
                                wb_sel    <= '1;
                                wb_adr    <= addr_next;
                                state_reg <= ST_RBUS;
                            end
                        end
                    end
                end
                ST_WDATA: begin
                    if (abort) begin
                        state_reg <= ST_IDLE;
                    end else if (rx_fire) begin
                        wdata_shift_reg <= wdata_next;
                        byte_cnt_reg    <= byte_cnt_reg + 4'd1;
                        if (byte_cnt_reg == 4'(BYTES - 1)) begin
                            byte_cnt_reg <= '0;
                            // After a bus error the rest of the frame is drained silently.
                            if (err_flag_reg) begin
                                if (words_left_reg == 9'd1)
                                    state_reg <= ST_IDLE;
                                words_left_reg <= words_left_reg - 9'd1;
                            end else begin
                                wb_cyc    <= 1'b1;
                                wb_stb    <= 1'b1;
                                wb_we     <= 1'b1;
                                wb_sel    <= '1;
                                wb_adr    <= addr_reg;
                                wb_dat_w  <= wdata_next;
                                state_reg <= ST_WBUS;
                            end
                        end
                    end
                end
                ST_WBUS: begin
                    if (wb_ack || wb_err) begin
                        wb_cyc <= 1'b0;
                        wb_stb <= 1'b0;
                        if (wb_err)
                            err_flag_reg <= 1'b1;
                        if (inc_mode_reg)
                            addr_reg <= addr_reg + ADDR_W'(1);
                        words_left_reg <= words_left_reg - 9'd1;
                        state_reg <= (words_left_reg == 9'd1) ? ST_IDLE : ST_WDATA;
                    end
                end
                ST_RBUS: begin
                    if (wb_ack || wb_err) begin
                        wb_cyc       <= 1'b0;
                        wb_stb       <= 1'b0;
                        tx_data_reg  <= rd_word[DATA_W-1 -: 8];
                        rdata_reg    <= rd_word << 8;
                        tx_valid_reg <= 1'b1;
                        byte_cnt_reg <= '0;
                        if (inc_mode_reg)
                            addr_reg <= addr_reg + ADDR_W'(1);
                        state_reg <= ST_RSEND;
                    end
                end
                ST_RSEND: begin
                    if (tx_valid_reg) begin
                        if (tx_ready) begin
                            byte_cnt_reg <= byte_cnt_reg + 4'd1;
                            if (byte_cnt_reg == 4'(BYTES - 1)) begin
                                tx_valid_reg <= 1'b0;
                            end else begin
                                tx_data_reg <= rdata_reg[DATA_W-1 -: 8];
                                rdata_reg   <= rdata_reg << 8;
                            end
                        end
                    end else if (tx_ready) begin
                        words_left_reg <= words_left_reg - 9'd1;
                        if (words_left_reg == 9'd1) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            wb_cyc    <= 1'b1;
                            wb_stb    <= 1'b1;
                            wb_adr    <= addr_reg;
                            state_reg <= ST_RBUS;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Directed bench for uart_wb_bridge: drives UART frames, models a Wishbone
// slave and decodes the UART reply stream.
module tb_uart_wb_bridge;
    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 30;
    localparam int TIMEOUT  = 400;
    localparam int BITC     = 10;

    typedef logic [7:0] bytes_t[$];

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                uart_rx = 1'b1;
    logic                uart_tx;
    logic                wb_cyc, wb_stb, wb_we;
    logic [ADDR_W-1:0]   wb_adr;
    logic [DATA_W-1:0]   wb_dat_w;
    logic [DATA_W/8-1:0] wb_sel;
    logic [DATA_W-1:0]   wb_dat_r = '0;
    logic                wb_ack = 1'b0;
    logic                wb_err = 1'b0;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0]        tx_got[$];
    logic [ADDR_W-1:0] log_adr[$];
    logic [DATA_W-1:0] log_dat[$];
    logic              log_we[$];
    logic [3:0]        log_sel[$];
    logic [DATA_W-1:0] rd_words[$];
    int                n_seen = 0;
    int                err_at = -1;
    int                b2b_viol = 0;
    bit                stall = 1'b0;
    logic [7:0]        mon_b;

    uart_wb_bridge #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_W(DATA_W),
        .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_dat_w(wb_dat_w), .wb_sel(wb_sel), .wb_dat_r(wb_dat_r),
        .wb_ack(wb_ack), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    // Wishbone slave: one-clock response latency, logs each transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wb_ack = 1'b0;
                wb_err = 1'b0;
            end else if (wb_ack || wb_err) begin
                wb_ack = 1'b0;
                wb_err = 1'b0;
                if (wb_stb || wb_cyc) b2b_viol++;
            end else if (wb_cyc && wb_stb && !stall) begin
                log_adr.push_back(wb_adr);
                log_dat.push_back(wb_dat_w);
                log_we.push_back(wb_we);
                log_sel.push_back(wb_sel);
                if (!wb_we) wb_dat_r = (rd_words.size() > 0) ? rd_words.pop_front() : '0;
                if (n_seen == err_at) wb_err = 1'b1;
                else wb_ack = 1'b1;
                $display("wb cycle %0d: adr=%h we=%b dat_w=%h dat_r=%h err=%b",
                         n_seen, wb_adr, wb_we, wb_dat_w, wb_dat_r, wb_err);
                n_seen++;
            end
        end
    end

    // UART reply decoder, sampling at mid-bit.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && uart_tx === 1'b0) begin
                repeat (5) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BITC) @(negedge clk);
                    mon_b[i] = uart_tx;
                end
                repeat (BITC) @(negedge clk);
                tx_got.push_back(mon_b);
                $display("uart tx byte %h", mon_b);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic good_stop);
        uart_rx = 1'b0;
        repeat (BITC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BITC) @(negedge clk);
        end
        uart_rx = good_stop;
        repeat (BITC) @(negedge clk);
        uart_rx = 1'b1;
        if (!good_stop) repeat (BITC) @(negedge clk);
    endtask

    task automatic send_frame(input bytes_t q);
        foreach (q[i]) send_byte(q[i], 1'b1);
        $display("frame sent: %0d bytes, cmd %h", q.size(), q[0]);
    endtask

    task automatic clear_logs();
        log_adr.delete(); log_dat.delete(); log_we.delete(); log_sel.delete();
        tx_got.delete(); rd_words.delete();
    endtask

    task automatic wait_tx(input int n);
        int budget = 3000;
        while (tx_got.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        repeat (20) @(negedge clk);
        vec_cnt++;
        if (tx_got.size() != n) begin
            $display("FAIL tx_count: got %0d bytes want %0d", tx_got.size(), n);
            err_cnt++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vec_cnt++; if (uart_tx !== 1'b1) begin $display("FAIL reset_tx: got %b want 1", uart_tx); err_cnt++; end
        vec_cnt++; if (wb_cyc !== 1'b0) begin $display("FAIL reset_cyc: got %b want 0", wb_cyc); err_cnt++; end
        vec_cnt++; if (wb_stb !== 1'b0) begin $display("FAIL reset_stb: got %b want 0", wb_stb); err_cnt++; end
        vec_cnt++; if (wb_we !== 1'b0) begin $display("FAIL reset_we: got %b want 0", wb_we); err_cnt++; end
        vec_cnt++; if (wb_adr !== '0) begin $display("FAIL reset_adr: got %h want 0", wb_adr); err_cnt++; end
        vec_cnt++; if (wb_dat_w !== '0) begin $display("FAIL reset_dat: got %h want 0", wb_dat_w); err_cnt++; end
        vec_cnt++; if (wb_sel !== '0) begin $display("FAIL reset_sel: got %h want 0", wb_sel); err_cnt++; end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_write_inc();
        clear_logs();
        send_frame('{8'h01, 8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78});
        repeat (40) @(negedge clk);
        vec_cnt++;
        if (log_adr.size() != 1) begin $display("FAIL wr_inc_count: got %0d cycles want 1", log_adr.size()); err_cnt++; end
        else begin
            vec_cnt++;
            if (log_adr[0] !== 30'h04000000 || log_dat[0] !== 32'h12345678 || log_we[0] !== 1'b1 || log_sel[0] !== 4'hF) begin
                $display("FAIL wr_inc_cycle: got adr=%h dat=%h we=%b sel=%h want adr=04000000 dat=12345678 we=1 sel=f",
                         log_adr[0], log_dat[0], log_we[0], log_sel[0]);
                err_cnt++;
            end
        end
    endtask

    task automatic test_addr_drop();
        clear_logs();
        send_frame('{8'h01, 8'h01, 8'hC0, 8'h00, 8'h00, 8'h07, 8'hAA, 8'h55, 8'h00, 8'hFF});
        repeat (40) @(negedge clk);
        vec_cnt++;
        if (log_adr.size() != 1) begin $display("FAIL addr_drop_count: got %0d cycles want 1", log_adr.size()); err_cnt++; end
        else begin
            vec_cnt++;
            if (log_adr[0] !== 30'h00000007 || log_dat[0] !== 32'hAA5500FF) begin
                $display("FAIL addr_drop_cycle: got adr=%h dat=%h want adr=00000007 dat=aa5500ff", log_adr[0], log_dat[0]);
                err_cnt++;
            end
        end
    endtask

    task automatic test_read_inc();
        logic [7:0] exp_tx[8] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
        logic [ADDR_W-1:0] exp_adr[2] = '{30'h2400, 30'h2401};
        clear_logs();
        rd_words.push_back(32'hDEADBEEF);
        rd_words.push_back(32'h01020304);
        send_frame('{8'h02, 8'h02, 8'h00, 8'h00, 8'h24, 8'h00});
        wait_tx(8);
        vec_cnt++;
        if (log_adr.size() != 2) begin $display("FAIL rd_inc_count: got %0d cycles want 2", log_adr.size()); err_cnt++; end
        for (int i = 0; i < 2 && i < log_adr.size(); i++) begin
            vec_cnt++;
            if (log_adr[i] !== exp_adr[i] || log_we[i] !== 1'b0) begin
                $display("FAIL rd_inc_adr%0d: got adr=%h we=%b want adr=%h we=0", i, log_adr[i], log_we[i], exp_adr[i]);
                err_cnt++;
            end
        end
        for (int i = 0; i < 8 && i < tx_got.size(); i++) begin
            vec_cnt++;
            if (tx_got[i] !== exp_tx[i]) begin
                $display("FAIL rd_inc_tx%0d: got %h want %h", i, tx_got[i], exp_tx[i]);
                err_cnt++;
            end
        end
    endtask

    task automatic test_write_fixed();
        logic [DATA_W-1:0] exp_dat[3] = '{32'h11111111, 32'h22222222, 32'h33333333};
        clear_logs();
        send_frame('{8'h03, 8'h03, 8'h00, 8'h00, 8'h00, 8'h10,
                     8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
                     8'h33, 8'h33, 8'h33, 8'h33});
        repeat (40) @(negedge clk);
        vec_cnt++;
        if (log_adr.size() != 3) begin $display("FAIL wr_fix_count: got %0d cycles want 3", log_adr.size()); err_cnt++; end
        for (int i = 0; i < 3 && i < log_adr.size(); i++) begin
            vec_cnt++;
            if (log_adr[i] !== 30'h10 || log_dat[i] !== exp_dat[i] || log_we[i] !== 1'b1) begin
                $display("FAIL wr_fix_cycle%0d: got adr=%h dat=%h we=%b want adr=00000010 dat=%h we=1",
                         i, log_adr[i], log_dat[i], log_we[i], exp_dat[i]);
                err_cnt++;
            end
        end
    endtask

    task automatic test_timeout();
        clear_logs();
        send_frame('{8'h01, 8'h01, 8'h00});
        repeat (TIMEOUT + 10) @(negedge clk);
        send_frame('{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h20, 8'hAA, 8'hBB, 8'hCC, 8'hDD});
        repeat (40) @(negedge clk);
        vec_cnt++;
        if (log_adr.size() != 1) begin $display("FAIL timeout_count: got %0d cycles want 1", log_adr.size()); err_cnt++; end
        else begin
            vec_cnt++;
            if (log_adr[0] !== 30'h20 || log_dat[0] !== 32'hAABBCCDD) begin
                $display("FAIL timeout_cycle: got adr=%h dat=%h want adr=00000020 dat=aabbccdd", log_adr[0], log_dat[0]);
                err_cnt++;
            end
        end
    endtask

    task automatic test_write_err();
        clear_logs();
        err_at = n_seen;
        send_frame('{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h30,
                     8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08});
        repeat (40) @(negedge clk);
        err_at = -1;
        vec_cnt++;
        if (log_adr.size() != 1) begin $display("FAIL wr_err_count: got %0d cycles want 1", log_adr.size()); err_cnt++; end
        clear_logs();
        rd_words.push_back(32'hCAFEF00D);
        send_frame('{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h40});
        wait_tx(4);
        vec_cnt++;
        if (log_adr.size() != 1 || log_adr[0] !== 30'h40) begin
            $display("FAIL wr_err_followup_adr: got %0d cycles adr=%h want 1 cycle adr=00000040",
                     log_adr.size(), (log_adr.size() > 0) ? log_adr[0] : '0);
            err_cnt++;
        end
        vec_cnt++;
        if (tx_got.size() != 4 || {tx_got[0], tx_got[1], tx_got[2], tx_got[3]} !== 32'hCAFEF00D) begin
            $display("FAIL wr_err_followup_data: got %0d bytes want cafef00d", tx_got.size());
            err_cnt++;
        end
    endtask

    task automatic test_read_err();
        logic [7:0] exp_tx[8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        clear_logs();
        rd_words.push_back(32'hFFFFFFFF);
        rd_words.push_back(32'h11223344);
        err_at = n_seen;
        send_frame('{8'h04, 8'h02, 8'h00, 8'h00, 8'h00, 8'h50});
        wait_tx(8);
        err_at = -1;
        vec_cnt++;
        if (log_adr.size() != 2 || log_adr[0] !== 30'h50 || log_adr[1] !== 30'h50) begin
            $display("FAIL rd_err_cycles: got %0d cycles want 2 at adr 00000050", log_adr.size());
            err_cnt++;
        end
        for (int i = 0; i < 8 && i < tx_got.size(); i++) begin
            vec_cnt++;
            if (tx_got[i] !== exp_tx[i]) begin
                $display("FAIL rd_err_tx%0d: got %h want %h", i, tx_got[i], exp_tx[i]);
                err_cnt++;
            end
        end
    endtask

    task automatic test_framing_err();
        clear_logs();
        send_frame('{8'h01, 8'h01, 8'h00, 8'h00});
        send_byte(8'h00, 1'b0);
        send_frame('{8'h00, 8'h55, 8'h66, 8'h77, 8'h88});
        repeat (40) @(negedge clk);
        vec_cnt++;
        if (log_adr.size() != 0) begin $display("FAIL ferr_no_bus: got %0d cycles want 0", log_adr.size()); err_cnt++; end
    endtask

    task automatic test_async_reset();
        int budget = 200;
        clear_logs();
        stall = 1'b1;
        send_frame('{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h60, 8'hA1, 8'hB2, 8'hC3, 8'hD4});
        while (!wb_stb && budget > 0) begin @(negedge clk); budget--; end
        vec_cnt++;
        if (wb_stb !== 1'b1) begin $display("FAIL async_stb_seen: got %b want 1", wb_stb); err_cnt++; end
        #2 rst_n = 1'b0;
        #1;
        vec_cnt++; if (wb_cyc !== 1'b0) begin $display("FAIL async_cyc: got %b want 0", wb_cyc); err_cnt++; end
        vec_cnt++; if (wb_stb !== 1'b0) begin $display("FAIL async_stb: got %b want 0", wb_stb); err_cnt++; end
        vec_cnt++;
        if (wb_we !== 1'b0 || wb_adr !== '0 || wb_dat_w !== '0 || wb_sel !== '0 || uart_tx !== 1'b1) begin
            $display("FAIL async_outputs: got we=%b adr=%h dat=%h sel=%h tx=%b want all 0, tx=1",
                     wb_we, wb_adr, wb_dat_w, wb_sel, uart_tx);
            err_cnt++;
        end
        @(negedge clk);
        stall = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        clear_logs();
        send_frame('{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h70, 8'h0F, 8'h1E, 8'h2D, 8'h3C});
        repeat (40) @(negedge clk);
        vec_cnt++;
        if (log_adr.size() != 1 || log_adr[0] !== 30'h70 || log_dat[0] !== 32'h0F1E2D3C) begin
            $display("FAIL post_reset_write: got %0d cycles want 1 at adr=00000070 dat=0f1e2d3c", log_adr.size());
            err_cnt++;
        end
    endtask

    task automatic test_protocol();
        vec_cnt++;
        if (b2b_viol !== 0) begin $display("FAIL strobe_after_ack: got %0d violations want 0", b2b_viol); err_cnt++; end
    endtask

    initial begin
        test_reset();
        test_write_inc();
        test_addr_drop();
        test_read_inc();
        test_write_fixed();
        test_timeout();
        test_write_err();
        test_read_err();
        test_framing_err();
        test_protocol();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
